vga_frame_monitor: RTL and testbench

- Receive-side checker for the VGA output of brick_breaker.
- Samples vga_hsync, vga_vsync, vga_blank and RGB at pixel rate.
- Measures line and frame timing against the expected mode, and declares lock after consecutive good frames.
- Produces sticky error flags and a per-frame pixel checksum, so benches and on-chip debug can verify the video stream without a monitor.

---
 rtl/vga_mon_pkg.sv | 23 ++
 rtl/vga_sync_edge.sv | 27 ++
 rtl/vga_frame_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA frame monitor.
// Counter widths bound the measured line and frame lengths.
package vga_mon_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } mon_state_t;

   localparam int ERR_H_TOTAL  = 0;
   localparam int ERR_H_ACTIVE = 1;
   localparam int ERR_V_TOTAL  = 2;
   localparam int ERR_V_ACTIVE = 3;

   localparam int HW = 12;
   localparam int VW = 11;
   localparam int GW = 8;

   localparam logic [HW-1:0] H_SAT = '1;
   localparam logic [VW-1:0] V_SAT = '1;

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one sync input on the pixel strobe and flags the
// transition into its asserted level.
module vga_sync_edge
   import vga_mon_pkg::*;
#(
   parameter bit POL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pix_ce,
   input  logic sync,
   output logic lead
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= 1'b0;
      end else if (pix_ce) begin
         prev <= sync;
      end
   end

   assign lead = pix_ce && (sync == POL) && (prev != POL);

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA timing checker: measures line/frame timing,
// tracks lock, keeps sticky error flags and a per-frame checksum.
module vga_frame_monitor
   import vga_mon_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_ce,
   input  logic          vga_hsync,
   input  logic          vga_vsync,
   input  logic          vga_blank,
   input  logic [7:0]    red,
   input  logic [7:0]    green,
   input  logic [7:0]    blue,
   input  logic          err_clr,
   output logic          lock,
   output logic [3:0]    err_flags,
   output logic          frame_done,
   output logic [31:0]   frame_sum,
   output logic [15:0]   frame_count,
   output logic [HW-1:0] meas_h_total,
   output logic [VW-1:0] meas_v_total
);

   localparam logic [HW-1:0] H_TOT = HW'(H_TOTAL);
   localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_TOT = VW'(V_TOTAL);
   localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);

   mon_state_t state, state_d;

   logic          h_lead, v_lead;
   logic [HW-1:0] h_cnt, act_cnt;
   logic          h_valid;
   logic [VW-1:0] line_cnt, act_lines;
   logic [VW-1:0] line_cl, act_lines_cl;
   logic [31:0]   frame_acc, pix_val;
   logic [GW-1:0] good, good_d;
   logic          frame_bad, frame_bad_d;
   logic          clr_hv;
   logic          h_chk, v_chk;
   logic [3:0]    new_err;

   vga_sync_edge #(.POL(HS_POL)) u_hs (
      .clk    (clk),
      .rst    (rst),
      .pix_ce (pix_ce),
      .sync   (vga_hsync),
      .lead   (h_lead)
   );

   vga_sync_edge #(.POL(VS_POL)) u_vs (
      .clk    (clk),
      .rst    (rst),
      .pix_ce (pix_ce),
      .sync   (vga_vsync),
      .lead   (v_lead)
   );

   assign pix_val = {8'd0, red, green, blue};
   assign lock    = (state == LOCKED);

   // Line close is folded into the counts before a coincident frame close.
   always_comb begin
      line_cl      = line_cnt;
      act_lines_cl = act_lines;
      if (h_lead) begin
         if (line_cnt != V_SAT) begin
            line_cl = line_cnt + 1'b1;
         end
         if (act_cnt != '0 && act_lines != V_SAT) begin
            act_lines_cl = act_lines + 1'b1;
         end
      end
   end

   always_comb begin
      h_chk   = h_lead && h_valid && (state != SEARCH);
      v_chk   = v_lead && (state != SEARCH);
      new_err = '0;
      new_err[ERR_H_TOTAL]  = h_chk && (h_cnt != H_TOT);
      new_err[ERR_H_ACTIVE] = h_chk && (act_cnt != '0)
                              && (act_cnt != H_ACT);
      new_err[ERR_V_TOTAL]  = v_chk && (line_cl != V_TOT);
      new_err[ERR_V_ACTIVE] = v_chk && (act_lines_cl != V_ACT);
   end

   always_comb begin
      state_d     = state;
      good_d      = good;
      frame_bad_d = frame_bad;
      clr_hv      = 1'b0;
      unique case (state)
         SEARCH: begin
            if (v_lead) begin
               state_d     = TRACK;
               good_d      = '0;
               frame_bad_d = 1'b0;
               clr_hv      = 1'b1;
            end
         end
         TRACK: begin
            if (|new_err) begin
               frame_bad_d = 1'b1;
            end
            if (v_lead) begin
               frame_bad_d = 1'b0;
               if (frame_bad || (|new_err)) begin
                  good_d = '0;
               end else begin
                  good_d = good + 1'b1;
                  if (int'(good) + 1 >= LOCK_FRAMES) begin
                     state_d = LOCKED;
                  end
               end
            end
         end
         LOCKED: begin
            // A frame broken mid-way must not count once back in TRACK.
            if (|new_err) begin
               state_d     = TRACK;
               good_d      = '0;
               frame_bad_d = !v_lead;
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SEARCH;
         good       <= '0;
         frame_bad  <= 1'b0;
         err_flags  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         good       <= good_d;
         frame_bad  <= frame_bad_d;
         err_flags  <= (err_clr ? 4'd0 : err_flags) | new_err;
         frame_done <= v_lead;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt        <= '0;
         act_cnt      <= '0;
         h_valid      <= 1'b0;
         meas_h_total <= '0;
      end else if (pix_ce) begin
         if (h_lead) begin
            meas_h_total <= h_cnt;
            h_cnt        <= HW'(1);
            act_cnt      <= HW'(vga_blank);
         end else begin
            if (h_cnt != H_SAT) begin
               h_cnt <= h_cnt + 1'b1;
            end
            if (vga_blank && act_cnt != H_SAT) begin
               act_cnt <= act_cnt + 1'b1;
            end
         end
         if (clr_hv) begin
            h_valid <= 1'b0;
         end else if (h_lead) begin
            h_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_cnt     <= '0;
         act_lines    <= '0;
         frame_acc    <= '0;
         frame_sum    <= '0;
         frame_count  <= '0;
         meas_v_total <= '0;
      end else if (pix_ce) begin
         if (v_lead) begin
            meas_v_total <= line_cl;
            frame_sum    <= frame_acc;
            frame_count  <= frame_count + 1'b1;
            line_cnt     <= '0;
            act_lines    <= '0;
            frame_acc    <= vga_blank ? pix_val : 32'd0;
         end else begin
            line_cnt  <= line_cl;
            act_lines <= act_lines_cl;
            if (vga_blank) begin
               frame_acc <= frame_acc + pix_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Small-mode bench: directed frames plus random frames, checked
// every cycle against a queue-based model of the video stream.
module tb_vga_frame_monitor;

   localparam int HA = 8;
   localparam int HT = 12;
   localparam int VA = 4;
   localparam int VT = 6;
   localparam int LF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_ce = 1'b0;
   logic        hs = 1'b1;
   logic        vs = 1'b1;
   logic        bl = 1'b0;
   logic [7:0]  r = '0;
   logic [7:0]  g = '0;
   logic [7:0]  b = '0;
   logic        err_clr = 1'b0;
   logic        lock;
   logic [3:0]  err_flags;
   logic        frame_done;
   logic [31:0] frame_sum;
   logic [15:0] frame_count;
   logic [11:0] meas_h_total;
   logic [10:0] meas_v_total;

   int n_checks = 0;
   int n_errors = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   vga_frame_monitor #(
      .H_ACTIVE    (HA),
      .H_TOTAL     (HT),
      .V_ACTIVE    (VA),
      .V_TOTAL     (VT),
      .HS_POL      (1'b0),
      .VS_POL      (1'b0),
      .LOCK_FRAMES (LF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_ce       (pix_ce),
      .vga_hsync    (hs),
      .vga_vsync    (vs),
      .vga_blank    (bl),
      .red          (r),
      .green        (g),
      .blue         (b),
      .err_clr      (err_clr),
      .lock         (lock),
      .err_flags    (err_flags),
      .frame_done   (frame_done),
      .frame_sum    (frame_sum),
      .frame_count  (frame_count),
      .meas_h_total (meas_h_total),
      .meas_v_total (meas_v_total)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  nm, got, exp, $time);
      end
   endtask

   // Model: pixels of the open line, active counts of closed lines,
   // and visible RGB values of the open frame.
   int          m_state, m_good;
   bit          m_bad, m_hv;
   logic        m_phs, m_pvs;
   bit          cur_line[$];
   int          fr_act[$];
   logic [31:0] fr_rgb[$];
   logic        e_lock, e_done;
   logic [3:0]  e_err;
   logic [31:0] e_sum;
   logic [15:0] e_count;
   logic [11:0] e_mh;
   logic [10:0] e_mv;

   task automatic model_reset();
      m_state = 0; m_good = 0; m_bad = 0; m_hv = 0;
      m_phs = 0; m_pvs = 0;
      cur_line.delete(); fr_act.delete(); fr_rgb.delete();
      e_lock = 0; e_done = 0; e_err = 0; e_sum = 0;
      e_count = 0; e_mh = 0; e_mv = 0;
   endtask

   task automatic model_step();
      logic [3:0]  ne;
      bit          hl, vl;
      int          len, act, nl, na;
      logic [31:0] s;
      ne = 0;
      e_done = 0;
      if (pix_ce) begin
         hl = (hs == 1'b0) && (m_phs != 1'b0);
         vl = (vs == 1'b0) && (m_pvs != 1'b0);
         m_phs = hs;
         m_pvs = vs;
         if (hl) begin
            len = cur_line.size();
            if (len > 4095) len = 4095;
            act = 0;
            foreach (cur_line[i]) if (cur_line[i]) act++;
            if (act > 4095) act = 4095;
            e_mh = len[11:0];
            if (m_state != 0 && m_hv) begin
               ne[0] = (len != HT);
               ne[1] = (act != 0) && (act != HA);
            end
            fr_act.push_back(act);
            m_hv = 1;
            cur_line.delete();
         end
         cur_line.push_back(bl);
         if (vl) begin
            nl = fr_act.size();
            if (nl > 2047) nl = 2047;
            na = 0;
            foreach (fr_act[i]) if (fr_act[i] != 0) na++;
            s = 0;
            foreach (fr_rgb[i]) s += fr_rgb[i];
            e_mv = nl[10:0];
            if (m_state != 0) begin
               ne[2] = (nl != VT);
               ne[3] = (na != VA);
            end
            e_sum = s;
            e_count++;
            e_done = 1;
            fr_act.delete();
            fr_rgb.delete();
         end
         if (bl) fr_rgb.push_back({8'h00, r, g, b});
         if (m_state == 0) begin
            if (vl) begin
               m_state = 1; m_good = 0; m_bad = 0; m_hv = 0;
            end
         end else if (m_state == 1) begin
            if (ne != 0) m_bad = 1;
            if (vl) begin
               if (m_bad) m_good = 0;
               else begin
                  m_good++;
                  if (m_good >= LF) m_state = 2;
               end
               m_bad = 0;
            end
         end else if (ne != 0) begin
            m_state = 1; m_good = 0; m_bad = !vl;
         end
      end
      e_err = (err_clr ? 4'h0 : e_err) | ne;
      e_lock = (m_state == 2);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("lock", 32'(lock), 32'(e_lock));
         chk("err_flags", 32'(err_flags), 32'(e_err));
         chk("frame_done", 32'(frame_done), 32'(e_done));
         chk("frame_sum", frame_sum, e_sum);
         chk("frame_count", 32'(frame_count), 32'(e_count));
         chk("meas_h_total", 32'(meas_h_total), 32'(e_mh));
         chk("meas_v_total", 32'(meas_v_total), 32'(e_mv));
         if (frame_done) n_done++;
      end
   end

   task automatic pix(input logic h, input logic v, input logic bb,
                      input logic [23:0] c, input int gap);
      hs = h; vs = v; bl = bb;
      {r, g, b} = c;
      pix_ce = 1'b1;
      @(posedge clk);
      #1;
      pix_ce = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic frame(input int vs_pos, input int long_line,
                        input int long_len, input int nact,
                        input int bad_act_line, input bit rnd,
                        input bit pause, input bit do_rst);
      for (int l = 0; l < VT; l++) begin
         int len;
         len = (l == long_line) ? long_len : HT;
         for (int i = 0; i < len; i++) begin
            logic        h, v, bb;
            logic [23:0] c;
            int          gap, aw;
            if (do_rst && l == 3 && i == 0) begin
               rst = 1'b1;
               #1;
               chk("rst_lock", 32'(lock), 32'd0);
               chk("rst_err", 32'(err_flags), 32'd0);
               chk("rst_count", 32'(frame_count), 32'd0);
               chk("rst_sum", frame_sum, 32'd0);
               @(posedge clk);
               #1;
               rst = 1'b0;
            end
            aw = (l == bad_act_line) ? HA - 1 : HA;
            h = !(i < 2);
            v = !(l < 2 && (l > 0 || i >= vs_pos));
            bb = (l >= 2) && (l < 2 + nact) && (i >= 2) && (i < 2 + aw);
            c = (rnd || !bb) ? 24'($urandom) : 24'h000001;
            gap = (pause && l == 3 && i == 5) ? 100 : $urandom_range(0, 2);
            if (rnd && $urandom_range(0, 99) == 0) err_clr = 1'b1;
            pix(h, v, bb, c, gap);
            err_clr = 1'b0;
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_lock", 32'(lock), 32'd0);
      chk("reset_err", 32'(err_flags), 32'd0);
      chk("reset_done", 32'(frame_done), 32'd0);
      chk("reset_count", 32'(frame_count), 32'd0);
      chk("reset_sum", frame_sum, 32'd0);
      chk("reset_mh", 32'(meas_h_total), 32'd0);
      chk("reset_mv", 32'(meas_v_total), 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 3; k++) frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t1_done_pulses", 32'(n_done), 32'd3);
      chk("t1_lock", 32'(lock), 32'd1);
      chk("t1_err", 32'(err_flags), 32'd0);
      chk("t1_sum", frame_sum, 32'd32);
      chk("t1_mh", 32'(meas_h_total), 32'd12);
      chk("t1_mv", 32'(meas_v_total), 32'd6);
      chk("t1_count", 32'(frame_count), 32'd3);

      frame(5, 3, 13, VA, -1, 0, 0, 0);
      chk("t2_err0", 32'(err_flags), 32'h1);
      chk("t2_lock_drop", 32'(lock), 32'd0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t2_lock_f1", 32'(lock), 32'd0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t2_lock_f2", 32'(lock), 32'd0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t2_relock", 32'(lock), 32'd1);
      clear_errs();
      chk("t2_clr", 32'(err_flags), 32'd0);

      frame(5, -1, HT, 3, -1, 0, 0, 0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t3_err3", 32'(err_flags), 32'h8);
      chk("t3_lock", 32'(lock), 32'd0);
      clear_errs();
      chk("t3_clr", 32'(err_flags), 32'd0);

      frame(0, -1, HT, VA, -1, 0, 0, 0);
      chk("t4_mv", 32'(meas_v_total), 32'd6);
      chk("t4_err", 32'(err_flags), 32'd0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t4_mv_next", 32'(meas_v_total), 32'd6);
      chk("t4_err_next", 32'(err_flags), 32'd0);

      frame(5, -1, HT, VA, -1, 0, 1, 0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t6_err", 32'(err_flags), 32'd0);
      chk("t6_lock", 32'(lock), 32'd1);
      chk("t6_count", 32'(frame_count), 32'd13);

      frame(5, -1, HT, VA, -1, 0, 0, 1);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t5_count", 32'(frame_count), 32'd1);
      chk("t5_search_lock", 32'(lock), 32'd0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t5_track_lock", 32'(lock), 32'd0);
      frame(5, -1, HT, VA, -1, 0, 0, 0);
      chk("t5_relock", 32'(lock), 32'd1);
      chk("t5_sum", frame_sum, 32'd32);
      chk("t5_err", 32'(err_flags), 32'd0);

      frame(5, 3, 4100, VA, -1, 0, 0, 0);
      chk("sat_err0", 32'(err_flags), 32'h1);
      chk("sat_lock", 32'(lock), 32'd0);

      for (int k = 0; k < 20; k++) begin
         int ll, lenv, na, bal;
         ll = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         lenv = $urandom_range(10, 14);
         na = ($urandom_range(0, 3) == 0) ? 3 : 4;
         bal = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 5)) : -1;
         frame($urandom_range(0, 11), ll, lenv, na, bal, 1, 0, 0);
      end
      repeat (4) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
